// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared FIFO pointer widths and Gray/binary helpers for the UART FIFO controllers
package uart_fifo_pkg;
   localparam int FIFO_ADDR_W = 4;
   localparam int PTR_W = FIFO_ADDR_W + 1;

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] b;
      b[PTR_W-1] = g[PTR_W-1];
      for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/gray_to_bin_n.sv
// gray_to_bin_n: combinational Gray-to-binary conversion, each bit the XOR of all Gray bits at or above it
module gray_to_bin_n #(
   parameter int n = 5
) (
   input  logic [n-1:0] i_gray,
   output logic [n-1:0] o_bin
);
   for (genvar i = 0; i < n; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[n-1:i];
   end
endmodule

// File: rtl/uart_fifo_wptr_ctl.sv
// uart_fifo_wptr_ctl: write-side pointer, RAM write strobe/address and registered Gray pointer,
// with full/almost-full/level/overflow status derived from the synchronized read Gray pointer
module uart_fifo_wptr_ctl
   import uart_fifo_pkg::*;
#(
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int AF_MARGIN = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_req,
   input  logic [ADDR_W:0]   i_rd_gptr_sync,
   input  logic              i_ovf_clr,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [ADDR_W:0]   o_wr_gptr,
   output logic              o_full,
   output logic              o_almost_full,
   output logic [ADDR_W:0]   o_wr_level,
   output logic              o_overflow
);
   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] AF_TH = PW'((1 << ADDR_W) - AF_MARGIN);

   logic [PW-1:0] r_wbin, r_wgray, r_level;
   logic          r_full, r_af, r_ovf;
   logic          w_accept;
   logic [PW-1:0] w_wbin_n, w_wgray_n, w_rbin, w_level_n, w_rgray_full;

   gray_to_bin_n #(.n(PW)) u_rd_g2b (
      .i_gray (i_rd_gptr_sync),
      .o_bin  (w_rbin)
   );

   assign w_accept  = i_wr_req & ~r_full & i_rst_n;
   assign w_wbin_n  = r_wbin + PW'(w_accept);
   assign w_wgray_n = w_wbin_n ^ (w_wbin_n >> 1);
   assign w_level_n = w_wbin_n - w_rbin;
   // Full means the write pointer is exactly one lap ahead: in Gray code that flips the top two bits
   assign w_rgray_full = {~i_rd_gptr_sync[ADDR_W:ADDR_W-1], i_rd_gptr_sync[ADDR_W-2:0]};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_af    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_n;
         r_wgray <= w_wgray_n;
         r_level <= w_level_n;
         r_full  <= (w_wgray_n == w_rgray_full);
         r_af    <= (w_level_n >= AF_TH);
         r_ovf   <= (i_wr_req & r_full) | (r_ovf & ~i_ovf_clr);
      end
   end

   assign o_wr_en       = w_accept;
   assign o_wr_addr     = r_wbin[ADDR_W-1:0];
   assign o_wr_gptr     = r_wgray;
   assign o_full        = r_full;
   assign o_almost_full = r_af;
   assign o_wr_level    = r_level;
   assign o_overflow    = r_ovf;
endmodule

// File: tb/tb_uart_fifo_wptr_ctl.sv
// tb_uart_fifo_wptr_ctl: directed-vector bench for the write pointer controller with ADDR_W=4, AF_MARGIN=2
module tb_uart_fifo_wptr_ctl;
   logic       clk = 1'b0;
   logic       rst_n, wr_req, ovf_clr;
   logic [4:0] rd_gptr_sync;
   logic       wr_en, full, almost_full, overflow;
   logic [3:0] wr_addr;
   logic [4:0] wr_gptr, wr_level;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [4:0] fill_gray [16] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                                  5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

   uart_fifo_wptr_ctl #(.ADDR_W(4), .AF_MARGIN(2)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_wr_req       (wr_req),
      .i_rd_gptr_sync (rd_gptr_sync),
      .i_ovf_clr      (ovf_clr),
      .o_wr_en        (wr_en),
      .o_wr_addr      (wr_addr),
      .o_wr_gptr      (wr_gptr),
      .o_full         (full),
      .o_almost_full  (almost_full),
      .o_wr_level     (wr_level),
      .o_overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   initial begin
      rst_n = 1'b0; wr_req = 1'b1; ovf_clr = 1'b0; rd_gptr_sync = '0;
      #1;
      check("rst_wr_en_pre", wr_en, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_wr_en", wr_en, 0);
      end
      check("rst_gptr", wr_gptr, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_level", wr_level, 0);
      check("rst_full", full, 0);
      check("rst_af", almost_full, 0);
      check("rst_ovf", overflow, 0);

      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("fill_wr_en", wr_en, 1);
         check("fill_addr", wr_addr, 32'(i));
         tick();
         check("fill_gptr", wr_gptr, fill_gray[i]);
         check("fill_level", wr_level, 32'(i + 1));
         check("fill_af", almost_full, (i + 1) >= 14);
         check("fill_full", full, (i + 1) == 16);
      end
      #1;
      check("ovf_wr_en", wr_en, 0);
      tick();
      check("ovf_set", overflow, 1);
      check("ovf_gptr_hold", wr_gptr, 5'd24);
      check("ovf_level_hold", wr_level, 16);

      ovf_clr = 1'b1;
      tick();
      check("ovf_set_wins", overflow, 1);
      wr_req = 1'b0;
      tick();
      check("ovf_clr", overflow, 0);
      ovf_clr = 1'b0;

      rd_gptr_sync = 5'b00001;
      tick();
      check("drain_full", full, 0);
      check("drain_level", wr_level, 15);
      check("drain_af", almost_full, 1);
      wr_req = 1'b1;
      #1;
      check("drain_wr_en", wr_en, 1);
      check("drain_addr", wr_addr, 0);
      tick();
      check("refill_full", full, 1);
      check("refill_level", wr_level, 16);
      check("refill_gptr", wr_gptr, 5'd25);
      #1;
      check("refill_wr_en", wr_en, 0);
      wr_req = 1'b0;

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; rd_gptr_sync = '0; wr_req = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("mid_level", wr_level, 7);
      check("mid_gptr", wr_gptr, 5'd4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", wr_en, 0);
      tick();
      check("mid_rst_gptr", wr_gptr, 0);
      check("mid_rst_level", wr_level, 0);
      check("mid_rst_addr", wr_addr, 0);
      check("mid_rst_wr_en2", wr_en, 0);

      rst_n = 1'b1;
      tick();
      tick();
      check("wrap_pre_level", wr_level, 2);
      for (int k = 2; k < 42; k++) begin
         rd_gptr_sync = gray((k - 1) % 32);
         #1;
         check("wrap_wr_en", wr_en, 1);
         check("wrap_addr", wr_addr, 32'(k % 16));
         tick();
         check("wrap_gptr", wr_gptr, gray((k + 1) % 32));
         check("wrap_level", wr_level, 2);
         check("wrap_full", full, 0);
         if (k + 1 == 32) check("wrap_gptr_zero", wr_gptr, 0);
      end
      wr_req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_fifo_wptr_ctl.md
# uart_fifo_wptr_ctl

Write-side pointer controller for the UART RX/TX asynchronous FIFOs. It tracks the binary write pointer, issues RAM write enables and addresses, and publishes a registered Gray-coded write pointer for clock-domain crossing. It also compares against the already-synchronized read Gray pointer to produce full, almost-full, fill level and overflow status. It sits between the UART receive datapath (the producer) and the dual-port FIFO RAM plus the write-to-read pointer synchronizer.

## Interface
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W, pointer width = ADDR_W+1
- AF_MARGIN, 2, almost_full asserts when level >= 2^ADDR_W - AF_MARGIN; legal range 1..2^ADDR_W-1

Ports:
- clk  in  1  write-domain clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- wr_req  in  1  producer write request, one entry per cycle
- rd_gptr_sync  in  ADDR_W+1  read Gray pointer, already 2-flop synchronized into clk domain
- ovf_clr  in  1  clears the sticky overflow flag
- wr_en  out  1  RAM write strobe (accepted write)
- wr_addr  out  ADDR_W  RAM write address
- wr_gptr  out  ADDR_W+1  registered Gray write pointer, for crossing to the read domain
- full  out  1  FIFO full (registered)
- almost_full  out  1  level threshold flag (registered)
- wr_level  out  ADDR_W+1  entries as seen from the write side, 0..2^ADDR_W (registered)
- overflow  out  1  sticky: wr_req seen while full

## Operation
- State registers: wbin, wgray, full, almost_full, wr_level, overflow. All reset to 0, so every output is 0 during reset.
- Accept: accept = wr_req & ~full & rst_n; wr_en = accept (combinational); wr_addr = wbin[ADDR_W-1:0].
- Next pointer: wbin_n = wbin + accept, modulo 2^(ADDR_W+1); wgray_n = wbin_n ^ (wbin_n >> 1).
- Full: full_n = (wgray_n == {~rd_gptr_sync[ADDR_W:ADDR_W-1], rd_gptr_sync[ADDR_W-2:0]}).
- Level: rbin = Gray-to-binary(rd_gptr_sync); wr_level_n = wbin_n - rbin, modulo 2^(ADDR_W+1).
- Almost full: almost_full_n = (wr_level_n >= 2^ADDR_W - AF_MARGIN).
- Overflow: set when wr_req & full; cleared by ovf_clr. If both occur in the same cycle, set wins.
- A write request while full is dropped: no wr_en, no pointer change.
- Pointer wrap at 2^(ADDR_W+1) is seamless. The MSB flip distinguishes full from empty.
- A stale rd_gptr_sync only makes full and level pessimistic. It never permits overwriting an unread entry.
- Reset mid-operation: all registers return to 0 on the first clock edge with rst_n low. wr_en is held 0 throughout reset.

## Timing
- wr_en and wr_addr are valid in the same cycle as wr_req, and the RAM captures on that edge.
- wbin and wr_gptr advance on the edge that samples accept. wr_gptr changes at most one bit per cycle and is driven straight from a flop, with no combinational path to the output.
- full, almost_full and wr_level reflect an accept or a rd_gptr_sync change one cycle later.
- Because full is computed from next-state values, full asserts on the edge of the 2^ADDR_W-th outstanding accept, and a back-to-back request is refused.
- Minimum full deassert latency after a read: read-domain edge, plus 2 synchronizer edges, plus 1 clk edge.

## Structure
- Shared package uart_fifo_pkg:
  - FIFO_ADDR_W default
  - PTR_W = ADDR_W+1
  - Gray/binary conversion functions for reuse by the read-side controller
- Sub-module gray_to_bin_n (parameter n): purely combinational XOR-prefix conversion, instantiated for rd_gptr_sync.
- Binary-to-Gray conversion is inline.

## Test plan
- Reset: rst_n=0 for 3 cycles with wr_req=1 -> wr_en=0 and all outputs 0; the first accept after release has wr_addr=0.
- Fill (ADDR_W=4, rd_gptr_sync=0):
  - 16 consecutive wr_req -> wr_addr 0..15; wr_gptr 0,1,3,2,6,7,5,4,12,...
  - full=1 and wr_level=16 after the 16th edge; almost_full=1 from level 14.
  - 17th request -> wr_en=0, overflow=1.
- Drain release: from full, rd_gptr_sync=00001 -> full=0 and wr_level=15 next cycle; one further write accepted, then full=1 again.
- Wrap: 40 writes with rd_gptr_sync tracking 2 behind -> wr_gptr returns to 00000 after 32 accepts; wr_level stays 2 across the wrap; full never asserts.
- Overflow priority: ovf_clr=1 in the same cycle as wr_req while full -> overflow stays 1; ovf_clr alone next cycle -> overflow=0.
- Reset mid-fill: rst_n low after 7 writes -> wbin, wr_gptr and wr_level return to 0 next edge; no wr_en during reset.
